// File: rtl/pid_scheduler_if.sv
// Request/response and core handshake bundle for pid_scheduler.
// Operand and result fields are two's complement values carried as raw bits.
interface pid_scheduler_if #(
    parameter int N_CH    = 4,
    parameter int D_WIDTH = 32,
    parameter int CH_W    = $clog2(N_CH)
);
    // channel side
    logic [N_CH-1:0]         req;
    logic [N_CH*D_WIDTH-1:0] req_target;
    logic [N_CH*D_WIDTH-1:0] req_meas;
    logic [N_CH-1:0]         ack;
    logic [D_WIDTH-1:0]      result;
    logic [CH_W-1:0]         result_ch;
    logic                    result_err;
    // shared core side
    logic                    core_start;
    logic [CH_W-1:0]         core_ch;
    logic [D_WIDTH-1:0]      core_target;
    logic [D_WIDTH-1:0]      core_meas;
    logic                    core_done;
    logic [D_WIDTH-1:0]      core_out;

    modport master (
        input  req, req_target, req_meas, core_done, core_out,
        output ack, result, result_ch, result_err,
        output core_start, core_ch, core_target, core_meas
    );

    modport slave (
        output req, req_target, req_meas, core_done, core_out,
        input  ack, result, result_ch, result_err,
        input  core_start, core_ch, core_target, core_meas
    );
endinterface

// File: rtl/pid_scheduler.sv
// Round-robin sequencer sharing one PID compute core among N_CH channels.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | no job; grant next requester (round-robin) when enabled
//   S_ISSUE | operands latched, core_start pulsed, timer cleared
//   S_WAIT  | waiting for core_done or for the timeout to expire
//   S_RESP  | one-cycle ack to the granted channel, last_grant updated
module pid_scheduler #(
    parameter int N_CH    = 4,
    parameter int D_WIDTH = 32,
    parameter int CH_W    = $clog2(N_CH),
    parameter int TIMEOUT = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    output logic            busy,
    pid_scheduler_if.master bus
);
    localparam int              TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [N_CH-1:0] ACK_ONE = N_CH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CH_W-1:0]    r_last_grant;
    logic [TW-1:0]      r_timer;
    logic [N_CH-1:0]    r_ack;
    logic [D_WIDTH-1:0] r_result;
    logic [CH_W-1:0]    r_result_ch;
    logic               r_result_err;
    logic               r_core_start;
    logic [CH_W-1:0]    r_core_ch;
    logic [D_WIDTH-1:0] r_core_target;
    logic [D_WIDTH-1:0] r_core_meas;
    logic               r_busy;

    logic [D_WIDTH-1:0] w_tgt  [N_CH];
    logic [D_WIDTH-1:0] w_meas [N_CH];
    logic [CH_W-1:0]    w_pick_ch;
    logic               w_pick_ok;

    for (genvar g = 0; g < N_CH; g++) begin : g_slice
        assign w_tgt[g]  = bus.req_target[g*D_WIDTH +: D_WIDTH];
        assign w_meas[g] = bus.req_meas[g*D_WIDTH +: D_WIDTH];
    end

    // Round-robin pick: scan from last_grant+1 with wrap. Scanning offsets
    // from far to near lets the nearest requester overwrite the others.
    always_comb begin
        w_pick_ok = 1'b0;
        w_pick_ch = '0;
        for (int k = N_CH; k >= 1; k--) begin
            int idx;
            idx = int'(r_last_grant) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (bus.req[CH_W'(idx)]) begin
                w_pick_ok = 1'b1;
                w_pick_ch = CH_W'(idx);
            end
        end
    end

    // Sequencer FSM; every output is registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_last_grant  <= CH_W'(N_CH - 1);
            r_timer       <= '0;
            r_ack         <= '0;
            r_result      <= '0;
            r_result_ch   <= '0;
            r_result_err  <= 1'b0;
            r_core_start  <= 1'b0;
            r_core_ch     <= '0;
            r_core_target <= '0;
            r_core_meas   <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            r_ack        <= '0;
            case (r_state)
                S_IDLE: begin
                    if (enable && w_pick_ok) begin
                        r_core_ch     <= w_pick_ch;
                        r_core_target <= w_tgt[w_pick_ch];
                        r_core_meas   <= w_meas[w_pick_ch];
                        r_core_start  <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // done has priority over a timeout in the same cycle
                    if (bus.core_done) begin
                        r_result     <= bus.core_out;
                        r_result_err <= 1'b0;
                        r_result_ch  <= r_core_ch;
                        r_ack        <= ACK_ONE << r_core_ch;
                        r_state      <= S_RESP;
                    end else if (r_timer == T_LAST) begin
                        r_result     <= '0;
                        r_result_err <= 1'b1;
                        r_result_ch  <= r_core_ch;
                        r_ack        <= ACK_ONE << r_core_ch;
                        r_state      <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    r_last_grant <= r_core_ch;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign bus.ack         = r_ack;
    assign bus.result      = r_result;
    assign bus.result_ch   = r_result_ch;
    assign bus.result_err  = r_result_err;
    assign bus.core_start  = r_core_start;
    assign bus.core_ch     = r_core_ch;
    assign bus.core_target = r_core_target;
    assign bus.core_meas   = r_core_meas;
endmodule

// File: tb/tb_pid_scheduler.sv
// Self-checking bench for pid_scheduler: directed scenarios followed by
// randomized jobs checked against a round-robin reference model.
module tb_pid_scheduler;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;
    logic busy;

    pid_scheduler_if #(.N_CH(N), .D_WIDTH(DW)) bus ();

    pid_scheduler #(.N_CH(N), .D_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            m_last = N - 1;
    logic [DW-1:0] m_result = '0;
    logic [1:0]    m_rch = '0;
    logic          m_err = 1'b0;
    logic [DW-1:0] tgt [N];
    logic [DW-1:0] mes [N];
    int            g_ch;
    time           g_ack_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_target[i*DW +: DW] = tgt[i];
            bus.req_meas[i*DW +: DW]   = mes[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            tgt[i] = $urandom;
            mes[i] = $urandom;
        end
        drive_ops();
    endtask

    // first requesting channel after the last grant, in rotation order
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Runs one job starting at an IDLE negedge with req/operands driven.
    // k_done < 0 means the core never answers.
    task automatic do_job(input int k_done, input logic [DW-1:0] cout,
                          input bit keep_req, input bit drop_mid);
        int            ch;
        logic [1:0]    chi;
        logic [DW-1:0] t_exp, m_exp, r_exp;
        logic [N-1:0]  a_exp;
        logic          e_exp;
        ch = rr_pick(bus.req, m_last);
        if (ch < 0) begin
            check("job_has_req", 64'(bus.req), 64'd1);
            return;
        end
        chi   = 2'(ch);
        t_exp = tgt[chi];
        m_exp = mes[chi];
        tick();
        check("core_start", 64'(bus.core_start), 64'd1);
        check("core_ch", 64'(bus.core_ch), 64'(chi));
        check("core_target", 64'(bus.core_target), 64'(t_exp));
        check("core_meas", 64'(bus.core_meas), 64'(m_exp));
        check("busy_issue", 64'(busy), 64'd1);
        g_ch = int'(bus.core_ch);
        tick();
        check("start_one_cycle", 64'(bus.core_start), 64'd0);
        if (drop_mid) begin
            bus.req[chi] = 1'b0;
            enable = 1'b0;
            tgt[chi] = $urandom;
            mes[chi] = $urandom;
            drive_ops();
        end
        for (int w = 0; w < TO; w++) begin
            if (w == k_done) begin
                bus.core_done = 1'b1;
                bus.core_out  = cout;
                tick();
                break;
            end
            check("no_early_ack", 64'(bus.ack), 64'd0);
            tick();
        end
        bus.core_done = 1'b0;
        if (drop_mid) enable = 1'b1;
        r_exp   = (k_done >= 0) ? cout : '0;
        e_exp   = (k_done < 0);
        a_exp   = 4'b0001 << chi;
        g_ack_t = $time;
        check("ack", 64'(bus.ack), 64'(a_exp));
        check("result", 64'(bus.result), 64'(r_exp));
        check("result_ch", 64'(bus.result_ch), 64'(chi));
        check("result_err", 64'(bus.result_err), 64'(e_exp));
        check("target_held", 64'(bus.core_target), 64'(t_exp));
        check("busy_resp", 64'(busy), 64'd1);
        m_last   = ch;
        m_result = r_exp;
        m_err    = e_exp;
        m_rch    = chi;
        if (!keep_req) bus.req[chi] = 1'b0;
        tick();
        check("ack_one_cycle", 64'(bus.ack), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("result_hold", 64'(bus.result), 64'(m_result));
        check("err_hold", 64'(bus.result_err), 64'(m_err));
        check("rch_hold", 64'(bus.result_ch), 64'(m_rch));
    endtask

    task automatic model_reset();
        m_last   = N - 1;
        m_result = '0;
        m_err    = 1'b0;
        m_rch    = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 64'(bus.ack), 64'd0);
        check({tag, "_result"}, 64'(bus.result), 64'd0);
        check({tag, "_rch"}, 64'(bus.result_ch), 64'd0);
        check({tag, "_err"}, 64'(bus.result_err), 64'd0);
        check({tag, "_start"}, 64'(bus.core_start), 64'd0);
        check({tag, "_core_ch"}, 64'(bus.core_ch), 64'd0);
        check({tag, "_target"}, 64'(bus.core_target), 64'd0);
        check({tag, "_meas"}, 64'(bus.core_meas), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            exp_order [5] = '{0, 1, 2, 3, 0};
        time           t_prev;
        logic [DW-1:0] val;
        int            k;

        bus.req       = '0;
        bus.core_done = 1'b0;
        bus.core_out  = '0;
        for (int i = 0; i < N; i++) begin
            tgt[i] = '0;
            mes[i] = '0;
        end
        drive_ops();

        // reset state
        #2 reset = 1'b0;
        #1 check_all_zero("reset");
        tick();
        tick();
        reset  = 1'b1;
        enable = 1'b1;

        // single request on channel 2
        tgt[2] = 32'd50;
        mes[2] = 32'd20;
        drive_ops();
        bus.req = 4'b0100;
        do_job(0, 32'd300, 0, 0);
        check("single_ch2", 64'(g_ch), 64'd2);

        // all four requesting continuously after a fresh reset
        reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        tick();
        rand_ops();
        bus.req = 4'b1111;
        t_prev  = 0;
        for (int j = 0; j < 5; j++) begin
            do_job(0, $urandom, 1, 0);
            check("rr_order", 64'(g_ch), 64'(exp_order[j]));
            if (j > 0) check("ack_spacing", 64'(g_ack_t - t_prev), 64'd40);
            t_prev = g_ack_t;
        end

        // timeout: core never answers
        bus.req = 4'b0001;
        rand_ops();
        do_job(-1, 32'hDEAD_BEEF, 0, 0);

        // done on the last timer cycle wins over the timeout
        bus.req = 4'b1000;
        rand_ops();
        do_job(TO - 1, 32'hFFFF_FF85, 0, 0);

        // core_done while idle is ignored
        bus.req       = '0;
        bus.core_done = 1'b1;
        bus.core_out  = 32'h1234_5678;
        tick();
        bus.core_done = 1'b0;
        check("idle_done_result", 64'(bus.result), 64'(m_result));
        check("idle_done_busy", 64'(busy), 64'd0);
        check("idle_done_start", 64'(bus.core_start), 64'd0);
        tick();
        check("idle_done_ack", 64'(bus.ack), 64'd0);

        // reset during WAIT discards the job
        rand_ops();
        bus.req = 4'b0100;
        tick();
        check("pre_rst_start", 64'(bus.core_start), 64'd1);
        tick();
        tick();
        reset   = 1'b0;
        bus.req = '0;
        #1 check_all_zero("midrst");
        tick();
        check("midrst_hold_ack", 64'(bus.ack), 64'd0);
        reset = 1'b1;
        model_reset();
        tick();
        check("post_rst_ack", 64'(bus.ack), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

        // enable low blocks grants; first grant after reset goes to ch 0
        enable  = 1'b0;
        bus.req = 4'b0011;
        rand_ops();
        for (int j = 0; j < 3; j++) begin
            tick();
            check("disabled_start", 64'(bus.core_start), 64'd0);
            check("disabled_busy", 64'(busy), 64'd0);
        end
        enable = 1'b1;
        do_job(2, $urandom, 0, 0);
        check("enable_grant_ch0", 64'(g_ch), 64'd0);

        // req[1] and enable dropped during WAIT: job still completes
        do_job(1, 32'h0000_0BAD, 0, 1);
        check("drop_grant_ch1", 64'(g_ch), 64'd1);

        // randomized jobs
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.req = '0;
                tick();
                check("gap_busy", 64'(busy), 64'd0);
                check("gap_start", 64'(bus.core_start), 64'd0);
            end
            rand_ops();
            bus.req = 4'($urandom_range(1, 15));
            k   = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1));
            val = $urandom;
            do_job(k, val, bit'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
